// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the result-bus (CDB) arbiter: datapath value, micro-op cell,
// requester index and the packed request bundle.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 3;
  localparam int CDB_IDX_W   = $clog2(CDB_NUM_REQ);

  typedef logic [31:0] phy_rf_data_t;

  // op[0] doubles as the valid flag on the writeback port
  typedef struct packed {
    logic [5:0] dest;
    logic [4:0] rob_addr;
    logic [3:0] op;
  } res_st_cell_t;

  typedef logic [CDB_IDX_W-1:0] cdb_req_idx_t;

  typedef struct packed {
    phy_rf_data_t value;
    res_st_cell_t op;
  } cdb_req_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester and writeback signals of the CDB arbiter. The execution-unit side
// (master) drives requests and flush; the arbiter (slave) returns grants and
// the registered writeback.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ
);

  logic [NUM_REQ-1:0] req_valid;
  phy_rf_data_t       req_value [NUM_REQ];
  res_st_cell_t       req_op    [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic               flush;
  phy_rf_data_t       value_out;
  res_st_cell_t       op_out;

  modport master (
    output req_valid, req_value, req_op, flush,
    input  req_ready, value_out, op_out
  );

  modport slave (
    input  req_valid, req_value, req_op, flush,
    output req_ready, value_out, op_out
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: starting at rr_ptr and wrapping,
// the first set request wins. Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  // scan from rr_ptr upward with wrap; first hit is the winner
  always_comb begin
    int j;
    logic [IDX_W-1:0] sel;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = IDX_W'(j);
      if (!gnt_vld && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: round-robin grant of one completed micro-op per cycle
// onto a registered writeback port, with flush that suppresses the grant.
// Optional per-requester grant/stall counters under QU_CDB_PERF_CNT_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = CDB_NUM_REQ,
  parameter int PERF_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef QU_CDB_PERF_CNT_EN
  output logic [PERF_CNT_WIDTH-1:0] perf_grant_cnt [NUM_REQ],
  output logic [PERF_CNT_WIDTH-1:0] perf_stall_cnt [NUM_REQ],
`endif
  cdb_arbiter_if.slave              bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  phy_rf_data_t       value_q, value_d;
  res_st_cell_t       op_q, op_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               take;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // grant is withheld during flush and while reset is held
  always_comb begin
    take          = gnt_vld && !bus.flush && !rst;
    bus.req_ready = take ? gnt : '0;
  end

  // next pointer and writeback capture; no grant clears valid but keeps value
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    value_d  = value_q;
    op_d     = '0;
    if (take) begin
      value_d   = bus.req_value[gnt_idx];
      op_d      = bus.req_op[gnt_idx];
      op_d.op[0] = 1'b1;
      rr_ptr_d  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // pointer and writeback register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      value_q  <= '0;
      op_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      value_q  <= value_d;
      op_q     <= op_d;
    end
  end

  assign bus.value_out = value_q;
  assign bus.op_out    = op_q;

`ifdef QU_CDB_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] grant_cnt_q [NUM_REQ];
  logic [PERF_CNT_WIDTH-1:0] grant_cnt_d [NUM_REQ];
  logic [PERF_CNT_WIDTH-1:0] stall_cnt_q [NUM_REQ];
  logic [PERF_CNT_WIDTH-1:0] stall_cnt_d [NUM_REQ];

  // saturating counters; stalls include flush cycles
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      stall_cnt_d[i] = stall_cnt_q[i];
      if (bus.req_valid[i] && bus.req_ready[i] && !(&grant_cnt_q[i]))
        grant_cnt_d[i] = grant_cnt_q[i] + PERF_CNT_WIDTH'(1);
      if (bus.req_valid[i] && !bus.req_ready[i] && !(&stall_cnt_q[i]))
        stall_cnt_d[i] = stall_cnt_q[i] + PERF_CNT_WIDTH'(1);
    end
  end

  // counter registers, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with NUM_REQ=3 (counter checks under
// QU_CDB_PERF_CNT_EN with 4-bit counters).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int PW = 4;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  cdb_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef QU_CDB_PERF_CNT_EN
  logic [PW-1:0] perf_grant_cnt [N];
  logic [PW-1:0] perf_stall_cnt [N];
`endif

  cdb_arbiter #(.NUM_REQ(N), .PERF_CNT_WIDTH(PW)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef QU_CDB_PERF_CNT_EN
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_value[i] = 32'h100 + 32'(i);
      bus.req_op[i]    = '{dest: 6'(i), rob_addr: 5'(10 + i), op: 4'b0010};
    end

    // reset with all requesters valid
    tick();
    tick();
    chk("rst_op_out", 32'(bus.op_out), 32'h0);
    chk("rst_value_out", bus.value_out, 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b0;
    #1;

    // all valid: 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      idx = k % 3;
      chk("rr_ready", 32'(bus.req_ready), 32'(1 << idx));
      tick();
      chk("rr_rob", 32'(bus.op_out.rob_addr), 32'(10 + idx));
      chk("rr_op", 32'(bus.op_out.op), 32'h3);
      chk("rr_value", bus.value_out, 32'h100 + 32'(idx));
    end
    chk("rr_ptr_wrap", 32'(dut.rr_ptr_q), 32'h0);

    // single requester 2 granted every cycle
    bus.req_valid = 3'b100;
    for (int k = 0; k < 4; k++) begin
      bus.req_value[2] = 32'hA5 + 32'(k);
      #1;
      chk("solo_ready", 32'(bus.req_ready), 32'h4);
      tick();
      chk("solo_value", bus.value_out, 32'hA5 + 32'(k));
      chk("solo_valid", 32'(bus.op_out.op[0]), 32'h1);
    end
    bus.req_valid = '0;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("idle_valid", 32'(bus.op_out.op[0]), 32'h0);
    chk("idle_value_hold", bus.value_out, 32'hA8);
    chk("solo_ptr", 32'(dut.rr_ptr_q), 32'h0);

    // flush with 0 and 1 valid
    bus.req_valid = 3'b011;
    bus.flush     = 1'b1;
    #1;
    chk("flush_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("flush_valid", 32'(bus.op_out.op[0]), 32'h0);
    chk("flush_ptr", 32'(dut.rr_ptr_q), 32'h0);
    bus.flush = 1'b0;
    #1;
    chk("post_flush_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("post_flush_rob", 32'(bus.op_out.rob_addr), 32'd10);
    chk("post_flush_ptr", 32'(dut.rr_ptr_q), 32'h1);

    // async reset mid-cycle while output valid
    tick();
    chk("pre_rst_rob", 32'(bus.op_out.rob_addr), 32'd11);
    chk("pre_rst_valid", 32'(bus.op_out.op[0]), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_op", 32'(bus.op_out), 32'h0);
    chk("async_rst_value", bus.value_out, 32'h0);
    chk("async_rst_ready", 32'(bus.req_ready), 32'h0);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("async_rst_ptr", 32'(dut.rr_ptr_q), 32'h0);

`ifdef QU_CDB_PERF_CNT_EN
    // requester 1 stalled behind flush for 20 cycles saturates at 15
    chk("perf_grant_clr", 32'(perf_grant_cnt[1]), 32'h0);
    bus.req_valid = 3'b010;
    bus.flush     = 1'b1;
    repeat (20) tick();
    chk("perf_stall_sat", 32'(perf_stall_cnt[1]), 32'd15);
    chk("perf_stall_other", 32'(perf_stall_cnt[0]), 32'h0);
    chk("perf_grant_none", 32'(perf_grant_cnt[1]), 32'h0);
    bus.flush = 1'b0;
    tick();
    chk("perf_grant_one", 32'(perf_grant_cnt[1]), 32'h1);
    chk("perf_stall_hold", 32'(perf_stall_cnt[1]), 32'd15);
    bus.req_valid = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
